// File: rtl/psum_credit_sender.sv
// psum_credit_sender
// Transmit end of the credit-based psum link. Outgoing psum words are held
// in a small FIFO and issued onto a valid-only link, one word per credit.
// Credits come back one at a time on credit_return, so the downstream
// buffer (MAX_CREDITS deep) can never be overrun.
//
// Ports:
//   clk           rising-edge clock
//   reset_n       asynchronous active-low reset
//   in_data       psum word from the PE datapath
//   in_valid      in_data valid
//   in_ready      FIFO can accept (based on the registered occupancy)
//   tx_data       registered link word
//   tx_valid      registered one-cycle pulse per word sent
//   credit_return one-cycle pulse, one credit given back by the receiver
//   credit_count  current credits (registered)
//   fifo_count    FIFO occupancy (registered)
//   idle          FIFO empty and all credits home
//   credit_err    sticky: a credit came back while already at MAX_CREDITS
module psum_credit_sender #(
    parameter int DATA_WIDTH   = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int MAX_CREDITS  = 4,
    parameter int CREDIT_WIDTH = 3,
    localparam int PTR_W       = $clog2(FIFO_DEPTH),
    localparam int CNT_W       = PTR_W + 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [DATA_WIDTH-1:0]   tx_data,
    output logic                    tx_valid,
    input  logic                    credit_return,
    output logic [CREDIT_WIDTH-1:0] credit_count,
    output logic [CNT_W-1:0]        fifo_count,
    output logic                    idle,
    output logic                    credit_err
);

    localparam logic [CNT_W-1:0]        FIFO_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [CREDIT_WIDTH-1:0] CRED_MAX  = CREDIT_WIDTH'(MAX_CREDITS);

    // IDLE: FIFO empty; ACTIVE: words waiting and credit available;
    // STALL: words waiting but no credit.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_STALL
    } state_t;

    state_t state_reg, state_next;

    logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]        fifo_count_reg, fifo_count_next;
    logic [CREDIT_WIDTH-1:0] credit_count_reg, credit_count_next;
    logic                    credit_err_reg, credit_err_next;
    logic                    tx_valid_reg;
    logic [DATA_WIDTH-1:0]   tx_data_reg;
    logic                    push, send;

    assign in_ready = (fifo_count_reg < FIFO_FULL);
    assign push     = in_valid && in_ready;
    // The state register is derived from the registered counters, so
    // ACTIVE is exactly "fifo_count > 0 and credit_count > 0".
    assign send     = (state_reg == ST_ACTIVE);

    always_comb begin
        fifo_count_next   = fifo_count_reg;
        credit_count_next = credit_count_reg;
        credit_err_next   = credit_err_reg;
        state_next        = state_reg;

        case ({push, send})
            2'b10:   fifo_count_next = fifo_count_reg + 1'b1;
            2'b01:   fifo_count_next = fifo_count_reg - 1'b1;
            default: fifo_count_next = fifo_count_reg;
        endcase

        case ({send, credit_return})
            2'b10: credit_count_next = credit_count_reg - 1'b1;
            2'b01: begin
                // A return with every credit already home is a protocol
                // violation by the receiver: saturate and flag it.
                if (credit_count_reg == CRED_MAX) begin
                    credit_err_next = 1'b1;
                end else begin
                    credit_count_next = credit_count_reg + 1'b1;
                end
            end
            default: credit_count_next = credit_count_reg;
        endcase

        if (fifo_count_next == '0) begin
            state_next = ST_IDLE;
        end else if (credit_count_next == '0) begin
            state_next = ST_STALL;
        end else begin
            state_next = ST_ACTIVE;
        end
    end

    // Storage has no reset so it maps onto plain RAM; stale contents are
    // never observable because the pointers and count are reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg        <= ST_IDLE;
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            fifo_count_reg   <= '0;
            credit_count_reg <= CRED_MAX;
            credit_err_reg   <= 1'b0;
            tx_valid_reg     <= 1'b0;
            tx_data_reg      <= '0;
        end else begin
            state_reg        <= state_next;
            fifo_count_reg   <= fifo_count_next;
            credit_count_reg <= credit_count_next;
            credit_err_reg   <= credit_err_next;
            tx_valid_reg     <= send;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (send) begin
                tx_data_reg <= mem[rd_ptr_reg];
                rd_ptr_reg  <= rd_ptr_reg + 1'b1;
            end
        end
    end

    assign tx_valid     = tx_valid_reg;
    assign tx_data      = tx_data_reg;
    assign fifo_count   = fifo_count_reg;
    assign credit_count = credit_count_reg;
    assign credit_err   = credit_err_reg;
    assign idle         = (state_reg == ST_IDLE) && (credit_count_reg == CRED_MAX);

endmodule

// File: tb/tb_psum_credit_sender.sv
module tb_psum_credit_sender;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        credit_return;
    logic [2:0]  credit_count;
    logic [2:0]  fifo_count;
    logic        idle;
    logic        credit_err;

    psum_credit_sender #(
        .DATA_WIDTH(16), .FIFO_DEPTH(4), .MAX_CREDITS(4), .CREDIT_WIDTH(3)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .tx_data(tx_data), .tx_valid(tx_valid),
        .credit_return(credit_return), .credit_count(credit_count),
        .fifo_count(fifo_count), .idle(idle), .credit_err(credit_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int tx_pulses = 0;

    // Reference model state
    logic [15:0] m_q[$];     // words buffered in the model FIFO
    logic [15:0] exp_q[$];   // scoreboard: words expected on the link
    int          m_credit = 4;
    bit          m_err = 0;
    bit          exp_pulse = 0;
    bit          mon_en = 0;

    // Link monitor: a word sent at edge k is visible at the following negedge.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (tx_valid !== exp_pulse) begin
                failures++;
                $display("FAIL tx_valid: got %b expected %b", tx_valid, exp_pulse);
            end
            if (exp_pulse && exp_q.size() > 0) begin
                logic [15:0] e;
                e = exp_q.pop_front();
                checks++;
                if (tx_data !== e) begin
                    failures++;
                    $display("FAIL tx_data: got %h expected %h", tx_data, e);
                end else begin
                    $display("tx word %h", tx_data);
                end
            end
            if (tx_valid === 1'b1) tx_pulses++;
        end
    end

    // One clock cycle of stimulus; model advanced from pre-edge state.
    task automatic step(input logic v, input logic [15:0] d, input logic cr);
        bit m_push, m_send;
        in_valid      = v;
        in_data       = d;
        credit_return = cr;
        m_push = v && (m_q.size() < 4);
        m_send = (m_q.size() > 0) && (m_credit > 0);
        if (m_send) exp_q.push_back(m_q.pop_front());
        if (m_push) m_q.push_back(d);
        if (m_send && !cr) m_credit--;
        else if (!m_send && cr) begin
            if (m_credit == 4) m_err = 1;
            else m_credit++;
        end
        exp_pulse = m_send;
        @(posedge clk);
        @(negedge clk);
        #1;
        in_valid      = 1'b0;
        credit_return = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (m_q.size() == 0 && m_credit == 4) break;
            step(1'b0, 16'h0, m_credit < 4);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 0; in_data = 0; credit_return = 0;
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk); #1;
        checks++; if (credit_count !== 3'd4) begin failures++; $display("FAIL reset_credit: got %0d expected 4", credit_count); end
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL reset_fifo: got %0d expected 0", fifo_count); end
        checks++; if (idle !== 1'b1) begin failures++; $display("FAIL reset_idle: got %b expected 1", idle); end
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_txv: got %b expected 0", tx_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
        checks++; if (credit_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", credit_err); end
        $display("reset checked");
        mon_en = 1;
    endtask

    task automatic test_single_word();
        step(1'b1, 16'h00A5, 1'b0);
        checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL single_fifo: got %0d expected 1", fifo_count); end
        step(1'b0, 16'h0, 1'b0);   // word leaves here
        checks++; if (credit_count !== 3'd3) begin failures++; $display("FAIL single_credit: got %0d expected 3", credit_count); end
        step(1'b0, 16'h0, 1'b0);
        checks++; if (idle !== 1'b0) begin failures++; $display("FAIL single_notidle: got %b expected 0", idle); end
        step(1'b0, 16'h0, 1'b1);
        checks++; if (credit_count !== 3'd4) begin failures++; $display("FAIL single_credit_back: got %0d expected 4", credit_count); end
        checks++; if (idle !== 1'b1) begin failures++; $display("FAIL single_idle: got %b expected 1", idle); end
    endtask

    task automatic test_credit_exhaustion();
        int p0;
        p0 = tx_pulses;
        for (int i = 1; i <= 6; i++) step(1'b1, 16'(i), 1'b0);
        step(1'b0, 16'h0, 1'b0);
        checks++; if (tx_pulses - p0 !== 4) begin failures++; $display("FAIL exh_pulses: got %0d expected 4", tx_pulses - p0); end
        checks++; if (credit_count !== 3'd0) begin failures++; $display("FAIL exh_credit: got %0d expected 0", credit_count); end
        checks++; if (fifo_count !== 3'd2) begin failures++; $display("FAIL exh_fifo: got %0d expected 2", fifo_count); end
        step(1'b0, 16'h0, 1'b1);
        step(1'b0, 16'h0, 1'b0);   // 0x0005 leaves here
        checks++; if (credit_count !== 3'd0) begin failures++; $display("FAIL exh_credit2: got %0d expected 0", credit_count); end
        checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL exh_fifo2: got %0d expected 1", fifo_count); end
        drain();
        checks++; if (idle !== 1'b1) begin failures++; $display("FAIL exh_idle: got %b expected 1", idle); end
    endtask

    task automatic test_full_wrap();
        for (int i = 0; i < 4; i++) step(1'b1, 16'h0040 + 16'(i), 1'b0);
        step(1'b0, 16'h0, 1'b0);   // last burn word leaves, credit now 0
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) step(1'b1, 16'h0010 + 16'(r * 16) + 16'(i), 1'b0);
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_ready: got %b expected 0", in_ready); end
            step(1'b1, 16'h0014 + 16'(r * 16), 1'b0);   // rejected
            checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL full_fifo: got %0d expected 4", fifo_count); end
            for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 1'b1);
            step(1'b0, 16'h0, 1'b0);
            checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL full_drained: got %0d expected 0", fifo_count); end
            checks++; if (credit_count !== 3'd0) begin failures++; $display("FAIL full_credit: got %0d expected 0", credit_count); end
        end
        drain();
        checks++; if (credit_count !== 3'd4) begin failures++; $display("FAIL full_restore: got %0d expected 4", credit_count); end
    endtask

    task automatic test_back_to_back();
        step(1'b1, 16'h0030, 1'b0);
        step(1'b1, 16'h0031, 1'b0);
        for (int i = 2; i < 10; i++) begin
            step(1'b1, 16'h0030 + 16'(i), 1'b1);
            checks++; if (credit_count !== 3'd3) begin failures++; $display("FAIL b2b_credit: got %0d expected 3", credit_count); end
        end
        checks++; if (credit_err !== 1'b0) begin failures++; $display("FAIL b2b_err: got %b expected 0", credit_err); end
        drain();
    endtask

    task automatic test_overflow_reset();
        step(1'b0, 16'h0, 1'b1);
        checks++; if (credit_count !== 3'd4) begin failures++; $display("FAIL ovf_credit: got %0d expected 4", credit_count); end
        checks++; if (credit_err !== 1'b1) begin failures++; $display("FAIL ovf_err: got %b expected 1", credit_err); end
        for (int i = 0; i < 4; i++) step(1'b1, 16'h0050 + 16'(i), 1'b0);
        step(1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 16'h0060 + 16'(i), 1'b0);
        checks++; if (fifo_count !== 3'd3) begin failures++; $display("FAIL ovf_buffered: got %0d expected 3", fifo_count); end
        checks++; if (credit_err !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b expected 1", credit_err); end
        // Asynchronous reset between clock edges
        mon_en = 0;
        reset_n = 1'b0;
        #1;
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL rst_fifo: got %0d expected 0", fifo_count); end
        checks++; if (credit_count !== 3'd4) begin failures++; $display("FAIL rst_credit: got %0d expected 4", credit_count); end
        checks++; if (credit_err !== 1'b0) begin failures++; $display("FAIL rst_err: got %b expected 0", credit_err); end
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL rst_txv: got %b expected 0", tx_valid); end
        @(negedge clk); #1;
        reset_n = 1'b1;
        m_q.delete(); exp_q.delete();
        m_credit = 4; m_err = 0; exp_pulse = 0;
        mon_en = 1;
        step(1'b0, 16'h0, 1'b0);
        step(1'b0, 16'h0, 1'b0);
        checks++; if (idle !== 1'b1) begin failures++; $display("FAIL rst_idle: got %b expected 1", idle); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_credit_exhaustion();
        test_full_wrap();
        test_back_to_back();
        test_overflow_reset();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_empty: got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/psum_credit_sender.md
Name: psum_credit_sender

Overview:
- Transmit end of the PE credit-based psum link.
- Buffers outgoing psum words in a small FIFO and drives them onto a valid-only link toward the downstream receiver.
- Spends one credit per word sent; regains one credit per credit_return pulse from the receiver's up/down occupancy counter.
- Never issues a word without a credit, so the downstream buffer can never overflow.

Parameters:
- DATA_WIDTH, 16, psum word width.
- FIFO_DEPTH, 4, local buffer entries (power of two, >=2).
- MAX_CREDITS, 4, initial credits; equals downstream buffer depth.
- CREDIT_WIDTH, 3, width of credit counter; must hold MAX_CREDITS.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in_data  input  DATA_WIDTH  psum word from PE datapath.
- in_valid  input  1  in_data valid.
- in_ready  output  1  FIFO can accept; combinational, = (fifo_count < FIFO_DEPTH).
- tx_data  output  DATA_WIDTH  word on link; registered.
- tx_valid  output  1  one-cycle pulse per word sent; registered.
- credit_return  input  1  one-cycle pulse, one credit returned by receiver.
- credit_count  output  CREDIT_WIDTH  current credits.
- fifo_count  output  log2(FIFO_DEPTH)+1  FIFO occupancy.
- idle  output  1  high when FIFO empty and credit_count == MAX_CREDITS.
- credit_err  output  1  sticky: credit return received while credit_count == MAX_CREDITS.

Behaviour:
- Reset (async assert, sync-release use):
  - FIFO pointers and fifo_count = 0; credit_count = MAX_CREDITS.
  - tx_valid = 0, tx_data = 0, credit_err = 0; idle = 1.
  - Reset mid-operation discards buffered words and restores full credit; tx_valid deasserts immediately.
- Push: on an edge with in_valid && in_ready, in_data is written at the write pointer; the write pointer wraps modulo FIFO_DEPTH. in_valid while full is ignored; upstream must hold the word.
- Send condition, evaluated each edge from pre-edge state: send = (fifo_count > 0) && (credit_count > 0).
- On send:
  - Head word goes to tx_data; tx_valid = 1 for exactly that cycle.
  - Read pointer advances, with wrap.
  - credit_count decrements.
- Otherwise tx_valid = 0 and tx_data holds its last value.
- Maximum throughput: one word per cycle.
- Latency: a word pushed into an empty FIFO at edge k appears with tx_valid after edge k+1. There is no bypass path.
- Simultaneous push and send: fifo_count unchanged. Push into a full FIFO is blocked even when a send occurs that cycle, because in_ready is based on the pre-edge count.
- Credit arithmetic, by {send, credit_return}:
  - 00: hold.
  - 10: -1.
  - 01: +1.
  - 11: unchanged.
- Credit overflow: credit_return with credit_count == MAX_CREDITS and no send that cycle.
  - credit_count saturates at MAX_CREDITS.
  - credit_err sets and holds until reset.
- Underflow cannot occur, since send requires credit > 0.
- FSM (state in register, outputs from datapath):
  - IDLE: FIFO empty.
  - ACTIVE: FIFO non-empty with credit > 0.
  - STALL: FIFO non-empty with credit == 0.
  - Transitions are re-evaluated each edge from next-state fifo_count/credit_count. STALL->ACTIVE on a credit_return; ACTIVE->IDLE when the last word is sent and no push occurs.
- Exposed counters are registered values, never next-state.

Test Plan:
- Reset then idle: release reset_n -> credit_count=4, fifo_count=0, idle=1, tx_valid=0, in_ready=1.
- Single word: push 0x00A5 at edge 1 -> tx_valid=1 with tx_data=0x00A5 after edge 2 only; credit_count=3; idle=0 until one credit_return brings credit_count back to 4.
- Credit exhaustion:
  - Stimulus: push 6 words back-to-back (0x0001..0x0006), no credit_return.
  - Response: exactly 4 tx_valid pulses carrying 0x0001..0x0004; credit_count=0; FSM=STALL; fifo_count=2.
  - Then one credit_return -> 0x0005 sent, credit_count returns to 0.
- Full FIFO with wrap:
  - Stimulus: credit held at 0, push 0x0010..0x0014.
  - Response: 4 accepted, in_ready=0 on the fifth attempt.
  - Then return 4 credits -> outputs are 0x0010..0x0013 in order; wrapped pointers are correct on a second fill with 0x0020..0x0023.
- Simultaneous send and credit_return: steady stream with credit_return every cycle -> credit_count constant, one word per cycle, no credit_err.
- Overflow and mid-operation reset:
  - credit_return while credit_count=4 -> credit_count stays 4, credit_err=1 and sticky.
  - Pulse reset_n low while 3 words are buffered -> fifo_count=0, credit_count=4, credit_err=0 immediately.
